// File: rtl/board_editor_pkg.sv
// Shared board geometry, port-B word/address types and the editor state enum.
// Used by board_editor, its address map and the port-B interface.
package board_editor_pkg;

  localparam int WORD_SIZE      = 32;
  localparam int LOG_WORD_SIZE  = 5;
  localparam int BOARD_SIZE     = 256;
  localparam int LOG_BOARD_SIZE = 8;
  localparam int LOG_MAX_ADDR   = 11;
  localparam int WORDS_PER_ROW  = BOARD_SIZE / WORD_SIZE;

  typedef logic [LOG_BOARD_SIZE-1:0] pos_t;
  typedef logic [LOG_MAX_ADDR-1:0]   word_addr_t;
  typedef logic [WORD_SIZE-1:0]      word_t;
  typedef logic [LOG_WORD_SIZE-1:0]  bit_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BLANK,
    READ,
    READ_WAIT,
    WRITE,
    CLEAR
  } edit_state_t;

  function automatic word_t bit_mask(input bit_idx_t idx);
    return word_t'(1) << idx;
  endfunction

endpackage

// File: rtl/board_editor_if.sv
// Port-B bus of the dual-port board RAM: one shared address for read and write.
interface board_editor_if;
  import board_editor_pkg::*;

  word_addr_t addr_out;
  word_t      data_w_out;
  logic       we_out;
  word_t      data_r_in;

  modport master (
    output addr_out,
    output data_w_out,
    output we_out,
    input  data_r_in
  );

  modport slave (
    input  addr_out,
    input  data_w_out,
    input  we_out,
    output data_r_in
  );

endinterface

// File: rtl/board_editor_cell_addr_map.sv
// Cell coordinate -> board word address and MSB-first bit index.
// Shared by every block that touches board memory so the mapping stays identical.
module board_editor_cell_addr_map
  import board_editor_pkg::*;
(
  input  pos_t       i_x,
  input  pos_t       i_y,
  output word_addr_t o_word_addr,
  output bit_idx_t   o_bit_idx
);

  // All terms are address-width so the sum wraps modulo the RAM depth.
  assign o_word_addr = word_addr_t'(i_y) * word_addr_t'(WORDS_PER_ROW)
                     + word_addr_t'(i_x >> LOG_WORD_SIZE);

  assign o_bit_idx = bit_idx_t'(WORD_SIZE - 1) - i_x[LOG_WORD_SIZE-1:0];

endmodule

// File: rtl/board_editor.sv
// Board editor: read-modify-write toggle of the cursor cell on RAM port B,
// gated to the renderer blank period. Optional whole-board clear with EDITOR_CLEAR_EN.
module board_editor
  import board_editor_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic clk_130mhz,
  input  logic rst_in,
  input  pos_t cursor_x_in,
  input  pos_t cursor_y_in,
  input  logic toggle_in,
  input  logic clear_in,
  input  logic render_done_in,
  board_editor_if.master port_b,
  output logic busy_out
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  edit_state_t r_state;
  pos_t        r_x;
  pos_t        r_y;
  word_addr_t  r_addr;
  word_t       r_data_w;
  logic        r_we;
  logic        r_busy;
  logic [CNT_W-1:0] r_lat_cnt;

  word_addr_t w_word_addr;
  bit_idx_t   w_bit_idx;
  logic       w_request;

`ifdef EDITOR_CLEAR_EN
  logic r_clear_req;
  assign w_request = toggle_in | clear_in;
`else
  logic w_unused_clear;
  assign w_unused_clear = clear_in;
  assign w_request      = toggle_in;
`endif

  board_editor_cell_addr_map u_addr_map (
    .i_x         (r_x),
    .i_y         (r_y),
    .o_word_addr (w_word_addr),
    .o_bit_idx   (w_bit_idx)
  );

  always_ff @(posedge clk_130mhz) begin
    if (rst_in) begin
      r_state   <= IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_addr    <= '0;
      r_data_w  <= '0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_lat_cnt <= '0;
`ifdef EDITOR_CLEAR_EN
      r_clear_req <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_we <= 1'b0;
          if (w_request) begin
            r_x     <= cursor_x_in;
            r_y     <= cursor_y_in;
            r_busy  <= 1'b1;
            r_state <= WAIT_BLANK;
`ifdef EDITOR_CLEAR_EN
            r_clear_req <= clear_in;
`endif
          end
        end

        WAIT_BLANK: begin
          if (render_done_in) begin
`ifdef EDITOR_CLEAR_EN
            if (r_clear_req) begin
              r_addr   <= '0;
              r_data_w <= '0;
              r_we     <= 1'b1;
              r_state  <= CLEAR;
            end else begin
              r_addr  <= w_word_addr;
              r_state <= READ;
            end
`else
            r_addr  <= w_word_addr;
            r_state <= READ;
`endif
          end
        end

        READ: begin
          r_lat_cnt <= '0;
          r_state   <= READ_WAIT;
        end

        // Past this point the toggle completes even if the blank period ends.
        READ_WAIT: begin
          if (r_lat_cnt == CNT_W'(READ_LATENCY - 1)) begin
            r_data_w <= port_b.data_r_in ^ bit_mask(w_bit_idx);
            r_we     <= 1'b1;
            r_state  <= WRITE;
          end else begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
          end
        end

        WRITE: begin
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

`ifdef EDITOR_CLEAR_EN
        // A word written in the cycle render_done_in fell is rewritten on resume.
        CLEAR: begin
          if (!render_done_in) begin
            r_we <= 1'b0;
          end else if (!r_we) begin
            r_we <= 1'b1;
          end else if (r_addr == '1) begin
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
`endif

        default: begin
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign port_b.addr_out   = r_addr;
  assign port_b.data_w_out = r_data_w;
  assign port_b.we_out     = r_we;
  assign busy_out          = r_busy;

endmodule

// File: tb/tb_board_editor.sv
// Self-checking bench for board_editor: behavioural 2-cycle port-B RAM,
// write scoreboard, one task per scenario. Clear tests follow EDITOR_CLEAR_EN.
module tb_board_editor;
  import board_editor_pkg::*;

  logic clk_130mhz = 1'b0;
  always #4 clk_130mhz = ~clk_130mhz;

  logic rst_in = 1'b1;
  logic toggle_in = 1'b0;
  logic clear_in = 1'b0;
  logic render_done_in = 1'b1;
  pos_t cursor_x_in = '0;
  pos_t cursor_y_in = '0;
  logic busy_out;

  board_editor_if bus ();

  board_editor #(.READ_LATENCY(2)) dut (
    .clk_130mhz     (clk_130mhz),
    .rst_in         (rst_in),
    .cursor_x_in    (cursor_x_in),
    .cursor_y_in    (cursor_y_in),
    .toggle_in      (toggle_in),
    .clear_in       (clear_in),
    .render_done_in (render_done_in),
    .port_b         (bus),
    .busy_out       (busy_out)
  );

  // Port-B RAM model: registered read plus output register, bench preload port.
  bit   [31:0] mem [2048];
  logic [31:0] rd1, rd2;
  logic        pre_we = 1'b0;
  logic [10:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk_130mhz) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.we_out === 1'b1) mem[bus.addr_out] <= bus.data_w_out;
    rd1 <= mem[bus.addr_out];
    rd2 <= rd1;
  end
  assign bus.data_r_in = rd2;

  typedef struct packed {
    logic [10:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  bit [31:0] shadow [2048];
  int checks = 0;
  int failures = 0;
  int writes = 0;
  bit sweep_mode = 1'b0;

  always @(negedge clk_130mhz) begin : monitor
    wr_t e;
    if (bus.we_out === 1'b1 && !sweep_mode) begin
      writes++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got addr=%0d data=%h required no write",
                 bus.addr_out, bus.data_w_out);
      end else begin
        e = exp_q.pop_front();
        if (bus.addr_out !== e.a || bus.data_w_out !== e.d) begin
          failures++;
          $display("FAIL write got addr=%0d data=%h required addr=%0d data=%h",
                   bus.addr_out, bus.data_w_out, e.a, e.d);
        end else begin
          $display("write addr=%0d data=%h ok", bus.addr_out, bus.data_w_out);
        end
      end
    end
  end

  function automatic logic [10:0] model_addr(input int x, input int y);
    return 11'((y * 8 + x / 32) % 2048);
  endfunction

  function automatic logic [31:0] model_mask(input int x);
    logic [31:0] m;
    m = 32'h1 << (31 - (x % 32));
    return m;
  endfunction

  task automatic preload(input int a, input logic [31:0] d);
    @(negedge clk_130mhz);
    pre_we = 1'b1; pre_addr = a[10:0]; pre_data = d;
    @(negedge clk_130mhz);
    pre_we = 1'b0;
    shadow[a] = d;
  endtask

  task automatic pulse_toggle(input int x, input int y, input bit expect_write);
    wr_t e;
    logic [10:0] a;
    a = model_addr(x, y);
    if (expect_write) begin
      e.a = a;
      e.d = shadow[a] ^ model_mask(x);
      shadow[a] = e.d;
      exp_q.push_back(e);
    end
    @(negedge clk_130mhz);
    cursor_x_in = x[7:0]; cursor_y_in = y[7:0]; toggle_in = 1'b1;
    @(negedge clk_130mhz);
    toggle_in = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk_130mhz);
      if (busy_out === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    repeat (3) @(negedge clk_130mhz);
    checks++;
    if (bus.we_out !== 1'b0 || busy_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got we=%b busy=%b required we=0 busy=0", bus.we_out, busy_out);
    end
    checks++;
    if (bus.addr_out !== 11'd0 || bus.data_w_out !== 32'd0) begin
      failures++;
      $display("FAIL reset_bus got addr=%0d data=%h required 0/0", bus.addr_out, bus.data_w_out);
    end
    rst_in = 1'b0;
    $display("reset done");
  endtask

  task automatic test_toggle_basic;
    preload(17, 32'h0);
    render_done_in = 1'b1;
    pulse_toggle(37, 2, 1'b1);
    repeat (4) @(negedge clk_130mhz);
    checks++;
    if (busy_out !== 1'b1) begin
      failures++;
      $display("FAIL busy_before_end got %b required 1", busy_out);
    end
    @(negedge clk_130mhz);
    checks++;
    if (busy_out !== 1'b0) begin
      failures++;
      $display("FAIL busy_fall_5 got %b required 0", busy_out);
    end
    checks++;
    if (mem[17] !== 32'h0400_0000) begin
      failures++;
      $display("FAIL toggle_basic_mem got %h required 04000000", mem[17]);
    end
  endtask

  task automatic test_toggle_repeat;
    bit ok;
    pulse_toggle(37, 2, 1'b1);
    wait_idle(50, ok);
    checks++;
    if (!ok || mem[17] !== 32'h0) begin
      failures++;
      $display("FAIL toggle_repeat got ok=%b mem=%h required ok=1 mem=0", ok, mem[17]);
    end
    preload(86, 32'hFFFF_0000);
    pulse_toggle(200, 10, 1'b1);
    wait_idle(50, ok);
    checks++;
    if (!ok || mem[86] !== 32'hFF7F_0000) begin
      failures++;
      $display("FAIL toggle_neighbours got ok=%b mem=%h required ok=1 mem=ff7f0000", ok, mem[86]);
    end
  endtask

  task automatic test_blank_gating;
    int nwe;
    bit ok;
    render_done_in = 1'b0;
    pulse_toggle(100, 5, 1'b1);
    cursor_x_in = '0; cursor_y_in = '0;
    nwe = 0;
    repeat (20) begin
      @(negedge clk_130mhz);
      if (bus.we_out !== 1'b0) nwe++;
    end
    checks++;
    if (nwe != 0 || busy_out !== 1'b1) begin
      failures++;
      $display("FAIL blank_hold got writes=%0d busy=%b required writes=0 busy=1", nwe, busy_out);
    end
    render_done_in = 1'b1;
    wait_idle(50, ok);
    checks++;
    if (!ok || mem[43] !== 32'h0800_0000 || mem[0] !== 32'h0) begin
      failures++;
      $display("FAIL blank_latched got ok=%b mem43=%h mem0=%h required 1/08000000/0",
               ok, mem[43], mem[0]);
    end
  endtask

  task automatic test_drop_while_busy;
    int w0;
    bit ok;
    w0 = writes;
    pulse_toggle(5, 0, 1'b1);
    @(negedge clk_130mhz);
    pulse_toggle(6, 1, 1'b0);
    wait_idle(50, ok);
    repeat (5) @(negedge clk_130mhz);
    checks++;
    if (!ok || writes - w0 != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drop_busy got ok=%b writes=%0d pending=%0d required 1/1/0",
               ok, writes - w0, exp_q.size());
    end
  endtask

  task automatic test_reset_midop;
    int nwe;
    preload(300, 32'h1234_5678);
    pulse_toggle(130, 37, 1'b0);
    repeat (2) @(negedge clk_130mhz);
    checks++;
    if (busy_out !== 1'b1) begin
      failures++;
      $display("FAIL midop_busy got %b required 1", busy_out);
    end
    rst_in = 1'b1;
    @(negedge clk_130mhz);
    checks++;
    if (bus.we_out !== 1'b0 || busy_out !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset got we=%b busy=%b required 0/0", bus.we_out, busy_out);
    end
    rst_in = 1'b0;
    nwe = 0;
    repeat (10) begin
      @(negedge clk_130mhz);
      if (bus.we_out !== 1'b0 || busy_out !== 1'b0) nwe++;
    end
    checks++;
    if (nwe != 0 || mem[300] !== 32'h1234_5678) begin
      failures++;
      $display("FAIL midop_nowrite got activity=%0d mem=%h required 0/12345678", nwe, mem[300]);
    end
  endtask

`ifdef EDITOR_CLEAR_EN
  task automatic test_clear;
    int exp_a, bad, stall_bad, nonzero, cyc;
    preload(0, 32'hDEAD_BEEF);
    preload(100, 32'h1);
    preload(2047, 32'h8000_0000);
    render_done_in = 1'b1;
    sweep_mode = 1'b1;
    exp_a = 0; bad = 0; stall_bad = 0; cyc = 0;
    @(negedge clk_130mhz);
    cursor_x_in = 8'd40; cursor_y_in = 8'd3; toggle_in = 1'b1; clear_in = 1'b1;
    @(negedge clk_130mhz);
    toggle_in = 1'b0; clear_in = 1'b0;
    while (exp_a <= 100 && cyc < 4000) begin
      @(negedge clk_130mhz); cyc++;
      if (bus.we_out === 1'b1) begin
        if (bus.addr_out !== exp_a[10:0] || bus.data_w_out !== 32'h0) bad++;
        exp_a++;
      end
    end
    render_done_in = 1'b0;
    repeat (5) begin
      @(negedge clk_130mhz);
      if (bus.we_out !== 1'b0 || bus.addr_out !== 11'd100) stall_bad++;
    end
    render_done_in = 1'b1;
    @(negedge clk_130mhz);
    checks++;
    if (bus.we_out !== 1'b1 || bus.addr_out !== 11'd100 || stall_bad != 0) begin
      failures++;
      $display("FAIL clear_resume got we=%b addr=%0d stall_errs=%0d required 1/100/0",
               bus.we_out, bus.addr_out, stall_bad);
    end
    exp_a = 101;
    while (busy_out === 1'b1 && cyc < 5000) begin
      @(negedge clk_130mhz); cyc++;
      if (bus.we_out === 1'b1) begin
        if (bus.addr_out !== exp_a[10:0] || bus.data_w_out !== 32'h0) bad++;
        exp_a++;
      end
    end
    sweep_mode = 1'b0;
    nonzero = 0;
    for (int i = 0; i < 2048; i++) begin
      if (mem[i] != 32'h0) nonzero++;
      shadow[i] = 32'h0;
    end
    checks++;
    if (bad != 0 || exp_a != 2048 || busy_out !== 1'b0) begin
      failures++;
      $display("FAIL clear_sweep got bad=%0d words=%0d busy=%b required 0/2048/0",
               bad, exp_a, busy_out);
    end
    checks++;
    if (nonzero != 0) begin
      failures++;
      $display("FAIL clear_mem got nonzero=%0d required 0", nonzero);
    end
    $display("clear sweep words=%0d", exp_a);
  endtask
`else
  task automatic test_clear_ignored;
    int act;
    act = 0;
    @(negedge clk_130mhz);
    clear_in = 1'b1;
    @(negedge clk_130mhz);
    clear_in = 1'b0;
    repeat (10) begin
      @(negedge clk_130mhz);
      if (busy_out !== 1'b0 || bus.we_out !== 1'b0) act++;
    end
    checks++;
    if (act != 0) begin
      failures++;
      $display("FAIL clear_ignored got activity=%0d required 0", act);
    end
    $display("clear request ignored");
  endtask
`endif

  task automatic test_back_to_back;
    bit ok;
    int x, y, diff;
    for (int n = 0; n < 4; n++) begin
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 255));
      pulse_toggle(x, y, 1'b1);
      wait_idle(50, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL b2b_timeout got busy=%b required 0", busy_out);
      end
    end
    diff = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] != shadow[i]) diff++;
    checks++;
    if (diff != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL memory_image got diffs=%0d pending=%0d required 0/0", diff, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_toggle_basic();
    test_toggle_repeat();
    test_blank_gating();
    test_drop_while_busy();
    test_reset_midop();
`ifdef EDITOR_CLEAR_EN
    test_clear();
`else
    test_clear_ignored();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
